// File: rtl/register_file.sv
// register_file: architectural registers with rename tags and a same-cycle commit bypass
//   clk_in/rst_in (async, active-low), rdy_in pauses state updates, flush_in clears all busy bits
//   rename_*: record the RoB entry producing a destination register
//   commit_*: RoB commit write; clears busy only when the tag still matches
//   rs1_*/rs2_*: combinational lookups returning a value or a pending RoB tag
module register_file #(
  parameter int RoB_WIDTH = 3,
  parameter int REG_NUM = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 rename_en,
  input  logic [4:0]           rename_reg,
  input  logic [RoB_WIDTH-1:0] rename_index,
  input  logic                 commit_en,
  input  logic [4:0]           commit_reg,
  input  logic [RoB_WIDTH-1:0] commit_index,
  input  logic [31:0]          commit_data,
  input  logic [4:0]           rs1_addr,
  output logic [31:0]          rs1_val,
  output logic                 rs1_busy,
  output logic [RoB_WIDTH-1:0] rs1_tag,
  input  logic [4:0]           rs2_addr,
  output logic [31:0]          rs2_val,
  output logic                 rs2_busy,
  output logic [RoB_WIDTH-1:0] rs2_tag
);
  logic [31:0]          regs [REG_NUM];
  logic [RoB_WIDTH-1:0] tags [REG_NUM];
  logic [REG_NUM-1:0]   busy;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      regs <= '{default: '0};
      tags <= '{default: '0};
      busy <= '0;
    end else if (rdy_in) begin
      if (commit_en && commit_reg != 5'd0) begin
        regs[commit_reg] <= commit_data;
        if (busy[commit_reg] && tags[commit_reg] == commit_index) busy[commit_reg] <= 1'b0;
      end
      // later assignments override the commit clear, so a same-cycle rename keeps the register busy
      if (flush_in) busy <= '0;
      else if (rename_en && rename_reg != 5'd0) begin
        busy[rename_reg] <= 1'b1;
        tags[rename_reg] <= rename_index;
      end
    end
  // outputs forced to zero while in reset so a pending commit cannot leak through the bypass
  function automatic logic [RoB_WIDTH+32:0] lookup(input logic [4:0] a);
    logic byp, bz;
    byp = commit_en && commit_reg == a && (!busy[a] || tags[a] == commit_index);
    bz = busy[a] && !byp;
    return (!rst_in || a == 5'd0) ? '0 :
      {byp ? commit_data : regs[a], bz, bz ? tags[a] : {RoB_WIDTH{1'b0}}};
  endfunction
  always_comb begin
    {rs1_val, rs1_busy, rs1_tag} = lookup(rs1_addr);
    {rs2_val, rs2_busy, rs2_tag} = lookup(rs2_addr);
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against an array-based model
module tb_register_file;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        rename_en = 1'b0;
  logic [4:0]  rename_reg = '0;
  logic [2:0]  rename_index = '0;
  logic        commit_en = 1'b0;
  logic [4:0]  commit_reg = '0;
  logic [2:0]  commit_index = '0;
  logic [31:0] commit_data = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [2:0]  rs1_tag, rs2_tag;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  logic [2:0]  m_tag  [32];
  register_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .rename_en(rename_en), .rename_reg(rename_reg), .rename_index(rename_index),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_index(commit_index),
    .commit_data(commit_data),
    .rs1_addr(rs1_addr), .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_addr(rs2_addr), .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
  );
  always #5 clk_in = ~clk_in;
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i] = '0;
    end
  endtask
  task automatic model_clock();
    logic ren;
    if (!rdy_in || !rst_in) return;
    ren = rename_en && rename_reg != 0 && !flush_in;
    if (commit_en && commit_reg != 0) begin
      m_regs[commit_reg] = commit_data;
      if (m_busy[commit_reg] && m_tag[commit_reg] == commit_index && !(ren && rename_reg == commit_reg))
        m_busy[commit_reg] = 1'b0;
    end
    if (flush_in) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    if (ren) begin
      m_busy[rename_reg] = 1'b1;
      m_tag[rename_reg] = rename_index;
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", nm, o, e);
    end
  endtask
  task automatic check_port(input string nm, input logic [4:0] a,
                            input logic [31:0] v, input logic b, input logic [2:0] t);
    logic [31:0] ev;
    logic eb;
    logic [2:0] et;
    if (!rst_in || a == 0) begin
      ev = 0; eb = 0; et = 0;
    end else if (commit_en && commit_reg == a && (!m_busy[a] || m_tag[a] == commit_index)) begin
      ev = commit_data; eb = 0; et = 0;
    end else begin
      ev = m_regs[a]; eb = m_busy[a]; et = m_tag[a];
    end
    chk({nm, "_busy"}, {31'd0, b}, {31'd0, eb});
    if (eb) chk({nm, "_tag"}, {29'd0, t}, {29'd0, et});
    else chk({nm, "_val"}, v, ev);
  endtask
  task automatic check_ports(input string nm);
    check_port({nm, "_rs1"}, rs1_addr, rs1_val, rs1_busy, rs1_tag);
    check_port({nm, "_rs2"}, rs2_addr, rs2_val, rs2_busy, rs2_tag);
  endtask
  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0; rename_en = 1'b0; commit_en = 1'b0;
  endtask
  task automatic step(input string nm);
    #1;
    check_ports(nm);
    @(posedge clk_in);
    model_clock();
    #1;
  endtask
  task automatic ren(input logic [4:0] r, input logic [2:0] i);
    rename_en = 1'b1; rename_reg = r; rename_index = i;
  endtask
  task automatic com(input logic [4:0] r, input logic [2:0] i, input logic [31:0] d);
    commit_en = 1'b1; commit_reg = r; commit_index = i; commit_data = d;
  endtask
  initial begin
    model_reset();
    rs1_addr = 5; rs2_addr = 0;
    #3;
    check_ports("in_reset");
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    step("after_reset");
    // rename then commit with bypass
    ren(5, 3); step("ren_x5");
    idle(); rs1_addr = 5; #1;
    chk("x5_busy", {31'd0, rs1_busy}, 32'd1);
    chk("x5_tag", {29'd0, rs1_tag}, 32'd3);
    step("x5_pending");
    com(5, 3, 32'hDEADBEEF); #1;
    chk("x5_bypass_val", rs1_val, 32'hDEADBEEF);
    chk("x5_bypass_busy", {31'd0, rs1_busy}, 32'd0);
    step("x5_commit");
    idle(); #1;
    chk("x5_state_val", rs1_val, 32'hDEADBEEF);
    step("x5_after");
    // stale commit
    ren(7, 1); step("ren_x7_1");
    ren(7, 4); step("ren_x7_4");
    idle(); com(7, 1, 32'h11); rs2_addr = 7; #1;
    chk("x7_stale_busy", {31'd0, rs2_busy}, 32'd1);
    chk("x7_stale_tag", {29'd0, rs2_tag}, 32'd4);
    step("x7_stale");
    idle(); step("x7_still_busy");
    com(7, 4, 32'h22); #1;
    chk("x7_bypass_val", rs2_val, 32'h22);
    step("x7_commit");
    idle(); #1;
    chk("x7_state_val", rs2_val, 32'h22);
    step("x7_after");
    // simultaneous rename and commit
    ren(9, 2); step("ren_x9");
    com(9, 2, 32'h55); ren(9, 6); step("x9_both");
    idle(); rs1_addr = 9; #1;
    chk("x9_busy", {31'd0, rs1_busy}, 32'd1);
    chk("x9_tag", {29'd0, rs1_tag}, 32'd6);
    step("x9_after");
    // flush with older commit and ignored rename
    ren(3, 0); step("ren_x3");
    ren(4, 1); step("ren_x4");
    ren(10, 5); step("ren_x10");
    idle(); flush_in = 1'b1; com(3, 0, 32'h77); ren(11, 7); step("flush");
    idle(); rs1_addr = 3; rs2_addr = 11; #1;
    chk("x3_val", rs1_val, 32'h77);
    chk("x11_busy", {31'd0, rs2_busy}, 32'd0);
    step("post_flush_a");
    rs1_addr = 4; rs2_addr = 10; #1;
    chk("x4_busy", {31'd0, rs1_busy}, 32'd0);
    chk("x10_busy", {31'd0, rs2_busy}, 32'd0);
    step("post_flush_b");
    rs1_addr = 9; #1;
    chk("x9_val", rs1_val, 32'h55);
    step("post_flush_c");
    // x0 ignored
    ren(0, 5); com(0, 5, 32'hFF); rs1_addr = 0; step("x0_write");
    idle(); #1;
    chk("x0_val", rs1_val, 32'd0);
    chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
    chk("x0_tag", {29'd0, rs1_tag}, 32'd0);
    step("x0_after");
    // pause
    rdy_in = 1'b0; com(2, 0, 32'h1); rs1_addr = 2; step("pause");
    idle(); #1;
    chk("x2_paused_val", rs1_val, 32'd0);
    step("pause_after");
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] cr;
      rdy_in = ($urandom_range(0, 9) != 0);
      flush_in = ($urandom_range(0, 19) == 0);
      rename_en = $urandom_range(0, 1);
      rename_reg = 5'($urandom_range(0, 7));
      rename_index = 3'($urandom);
      cr = 5'($urandom_range(0, 7));
      commit_en = $urandom_range(0, 1);
      commit_reg = cr;
      commit_index = $urandom_range(0, 1) ? m_tag[cr] : 3'($urandom);
      commit_data = $urandom;
      rs1_addr = $urandom_range(0, 3) == 0 ? cr : 5'($urandom_range(0, 8));
      rs2_addr = 5'($urandom_range(0, 8));
      step("rand");
    end
    // asynchronous reset mid-cycle, with a bypass-eligible commit pending
    idle(); ren(6, 2); step("pre_areset");
    idle(); com(5, 0, 32'hCAFEF00D); rs1_addr = 5; rs2_addr = 6;
    #2;
    rst_in = 1'b0;
    model_reset();
    #1;
    chk("areset_rs1_val", rs1_val, 32'd0);
    chk("areset_rs2_busy", {31'd0, rs2_busy}, 32'd0);
    chk("areset_rs2_tag", {29'd0, rs2_tag}, 32'd0);
    check_ports("areset");
    idle();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rs1_addr = 5; rs2_addr = 7;
    step("post_areset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
Architectural register file with rename tags. It sits between the Dispatcher and the reorder buffer and receives the commit stream that the reorder buffer drives on RF_update_*. At dispatch it records which RoB entry will produce each destination register. It answers the Dispatcher's two source-operand lookups with either a value or a pending RoB tag, and it clears all pending tags on a flush.

Parameters:
RoB_WIDTH, 3, width of a RoB index / rename tag
REG_NUM, 32, number of architectural registers (x0 hard-wired to zero)

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; low = pause, no state change
flush_in  input  1  misprediction flush from reorder buffer
rename_en  input  1  Dispatcher issues an instruction with a destination register
rename_reg  input  5  destination register of the issued instruction
rename_index  input  RoB_WIDTH  RoB entry allocated to that instruction
commit_en  input  1  reorder buffer commit write (RF_update_en)
commit_reg  input  5  committed destination register (RF_update_reg)
commit_index  input  RoB_WIDTH  RoB entry being committed (RF_update_index)
commit_data  input  32  committed value (RF_update_data)
rs1_addr  input  5  source register 1 lookup
rs1_val  output  32  value of rs1 when not busy
rs1_busy  output  1  rs1 is waiting on a RoB entry
rs1_tag  output  RoB_WIDTH  RoB entry producing rs1 (valid when rs1_busy)
rs2_addr  input  5  source register 2 lookup
rs2_val  output  32  value of rs2
rs2_busy  output  1  rs2 pending
rs2_tag  output  RoB_WIDTH  producer of rs2

Behaviour:
- State: regs[0..REG_NUM-1] (32b), busy[0..REG_NUM-1], tag[0..REG_NUM-1] (RoB_WIDTH). All state changes on posedge clk_in.
- Reset (rst_in=0, async): all regs=0, busy=0, tag=0. Lookup outputs are combinational, so they read val=0, busy=0, tag=0 for every address while in reset and after it.
- rdy_in=0: no state update; lookups continue combinationally.
- Commit (commit_en=1, commit_reg!=0):
  - regs[commit_reg] <= commit_data, unconditionally.
  - busy[commit_reg] <= 0 only if busy=1, tag==commit_index, and no rename of the same register in this cycle.
  - A tag mismatch means a newer producer exists, so busy and tag are kept.
- Rename (rename_en=1, rename_reg!=0, flush_in=0): busy[rename_reg] <= 1, tag[rename_reg] <= rename_index.
- Rename and commit to the same register in the same cycle: the data write still happens, and the rename wins busy and tag (busy=1, tag=rename_index).
- Writes and renames to x0 are ignored. x0 is always val=0, busy=0, tag=0.
- Flush (flush_in=1):
  - All busy <= 0; tags are don't-care.
  - rename_en is ignored that cycle.
  - A commit in the same cycle still writes regs, because it is older than the flushed work.
  - State is consistent the cycle after flush_in deasserts.
- Lookup, per port, combinational, 0-cycle latency, evaluated against current state plus a same-cycle commit bypass:
  - addr==0: val=0, busy=0.
  - Else if commit_en, commit_reg==addr, and (busy[addr]==0 or tag[addr]==commit_index): val=commit_data, busy=0.
  - Else if busy[addr]: busy=1, tag=tag[addr], val=regs[addr] (don't-care).
  - Else: val=regs[addr], busy=0.
  - A same-cycle rename never affects lookups in that cycle, since an instruction's sources are read before its own destination is renamed.
  - The bypass applies even when flush_in or rdy_in gates the state update; the Dispatcher is stalled in those cycles.
- rs1 and rs2 are fully independent; the same address on both ports returns identical results.
- Implementation: single always block with async reset for state, plus combinational lookup logic.

Test Plan:
- Reset then query: release rst_in; rs1_addr=5, rs2_addr=0 -> both val=0, busy=0.
- Rename then commit: rename x5 with index 3. Next cycle, rs1_addr=5 -> busy=1, tag=3. Commit x5, index 3, data 0xDEADBEEF; in the same cycle rs1 -> val=0xDEADBEEF, busy=0 via bypass. After the clock, busy[5]=0 and val=0xDEADBEEF from state.
- Stale commit: rename x7 to index 1, then to index 4. Commit x7, index 1, data 0x11 -> regs[7]=0x11 but rs2 lookup of 7 shows busy=1, tag=4. Commit x7, index 4, data 0x22 -> busy=0, val=0x22.
- Simultaneous rename and commit to x9: tag=2 outstanding; commit index 2, data 0x55 while renaming x9 to index 6 -> after the clock, regs[9]=0x55, busy=1, tag=6.
- Flush: x3, x4, x10 busy; assert flush_in with a commit x3=0x77 (tag match) and rename x11 -> after the clock, every busy=0, regs[3]=0x77, x11 not busy.
- x0 and pause:
  - Rename x0 and commit x0 with data 0xFF -> x0 stays val=0, busy=0.
  - With rdy_in=0, commit x2 with data 0x1 -> regs[2] unchanged after the clock.
  - Assert rst_in low asynchronously mid-run -> all lookups return 0 immediately without waiting for a clock edge.
